// File: rtl/x2050_core_store_if.sv
// x2050_core_store_if: pipelined Wishbone link between the main-store initiator and the core store
interface x2050_core_store_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  modport master(output cyc, stb, we, addr, wdata, sel, input stall, ack, err, rdata);
  modport slave(input cyc, stb, we, addr, wdata, sel, output stall, ack, err, rdata);
endinterface

// File: rtl/x2050_core_store.sv
// x2050_core_store: 2050 main/bump storage responder with programmable latency and bus error on unmapped words
module x2050_core_store #(
  parameter int MAIN_AW = 14,
  parameter int BUMP_AW = 8,
  parameter int LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  x2050_core_store_if.slave    wb,
  output logic                 o_busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [MAIN_AW-1:0] midx_q, midx;
  logic [BUMP_AW-1:0] bidx_q, bidx;
  logic bump_q, bump_sel;
  logic [31:0] main_mem [2**MAIN_AW];
  logic [31:0] bump_mem [2**BUMP_AW];
  logic main_hit, bump_hit, mapped, accept, resp_n, err_n;
  logic [31:0] rd_word, merged;
  assign main_hit = wb.addr[29:22] == 8'h00 && (wb.addr[21:0] >> MAIN_AW) == 22'd0;
  assign bump_hit = wb.addr[29:22] == 8'h01 && (wb.addr[21:0] >> BUMP_AW) == 22'd0;
  assign mapped   = main_hit | bump_hit;
  assign accept   = wb.cyc & wb.stb & (state != BUSY);
  assign wb.stall = state == BUSY;
  assign o_busy   = state != IDLE;
  // While waiting out the latency the bus address may change, so read from the captured index
  assign midx     = state == BUSY ? midx_q : wb.addr[MAIN_AW-1:0];
  assign bidx     = state == BUSY ? bidx_q : wb.addr[BUMP_AW-1:0];
  assign bump_sel = state == BUSY ? bump_q : bump_hit;
  assign rd_word  = bump_sel ? bump_mem[bidx] : main_mem[midx];
  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++)
      if (accept && wb.we && wb.sel[b]) merged[8*b +: 8] = wb.wdata[8*b +: 8];
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == BUSY) begin
      state_n = !wb.cyc ? IDLE : cnt == 4'd1 ? RESP : BUSY;
      cnt_n   = (!wb.cyc || cnt == 4'd1) ? 4'd0 : cnt - 4'd1;
    end else if (accept) begin
      state_n = (!mapped || LATENCY == 0) ? RESP : BUSY;
      cnt_n   = (!mapped || LATENCY == 0) ? 4'd0 : 4'(LATENCY);
    end else begin
      state_n = IDLE;
    end
  end
  assign resp_n = state_n == RESP;
  assign err_n  = accept & ~mapped;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wb.ack   <= 1'b0;
      wb.err   <= 1'b0;
      wb.rdata <= 32'd0;
      midx_q   <= '0;
      bidx_q   <= '0;
      bump_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wb.ack <= resp_n & ~err_n;
      wb.err <= err_n;
      if (resp_n && !err_n) wb.rdata <= merged;
      if (accept) begin
        midx_q <= wb.addr[MAIN_AW-1:0];
        bidx_q <= wb.addr[BUMP_AW-1:0];
        bump_q <= bump_hit;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (accept && wb.we)
      for (int b = 0; b < 4; b++)
        if (wb.sel[b]) begin
          if (main_hit) main_mem[wb.addr[MAIN_AW-1:0]][8*b +: 8] <= wb.wdata[8*b +: 8];
          if (bump_hit) bump_mem[wb.addr[BUMP_AW-1:0]][8*b +: 8] <= wb.wdata[8*b +: 8];
        end
  end
endmodule

// File: tb/tb_x2050_core_store.sv
// tb_x2050_core_store: directed and randomized checks of the core store against a word-level storage model
module tb_x2050_core_store;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cyc = 0, stb = 0, we = 0;
  logic [29:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [3:0] sel = 0;
  logic busy_a, busy_b;
  x2050_core_store_if ifa(), ifb();
  assign ifa.cyc = cyc;   assign ifb.cyc = cyc;
  assign ifa.stb = stb;   assign ifb.stb = stb;
  assign ifa.we = we;     assign ifb.we = we;
  assign ifa.addr = addr; assign ifb.addr = addr;
  assign ifa.wdata = wdata; assign ifb.wdata = wdata;
  assign ifa.sel = sel;   assign ifb.sel = sel;
  x2050_core_store #(.MAIN_AW(14), .BUMP_AW(8), .LATENCY(2)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .wb(ifa), .o_busy(busy_a));
  x2050_core_store #(.MAIN_AW(14), .BUMP_AW(8), .LATENCY(0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .wb(ifb), .o_busy(busy_b));
  int vec = 0, errs = 0;
  logic [31:0] mdl [int unsigned];
  logic [31:0] last_a = 0;
  function automatic bit is_mapped(logic [29:0] a);
    return a < 30'd16384 || (a >= 30'h400000 && a < 30'h400100);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  // One request through the LATENCY=2 store; k is the sample index of the response (-1 on timeout)
  task automatic txn(input logic w, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int k, output logic ak, output logic er, output logic [31:0] rd,
                     output int st, output logic tl);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    stb = 0; k = -1; st = 0; ak = 0; er = 0; rd = 0;
    for (int i = 1; i <= 20; i++) begin
      if (ifa.ack || ifa.err) begin
        k = i; ak = ifa.ack; er = ifa.err; rd = ifa.rdata;
        break;
      end
      st += int'(ifa.stall);
      @(negedge clk);
    end
    @(negedge clk);
    tl = ifa.ack | ifa.err;
    cyc = 0;
  endtask
  task automatic test_reset();
    #12;
    vec++;
    if ({ifa.ack, ifa.err, ifa.stall, busy_a, ifb.ack, ifb.err, ifb.stall, busy_b} !== 8'h00 ||
        ifa.rdata !== 32'd0 || ifb.rdata !== 32'd0) begin
      errs++;
      $display("FAIL reset_outputs: a ack%b err%b stall%b busy%b data %h, b data %h; want all 0",
               ifa.ack, ifa.err, ifa.stall, busy_a, ifa.rdata, ifb.rdata);
    end
    @(negedge clk);
    rst_n = 1;
    last_a = 0;
  endtask
  task automatic test_basic();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    txn(1, 30'h10, 32'hDEADBEEF, 4'hF, k, ak, er, rd, st, tl);
    mdl[30'h10] = 32'hDEADBEEF;
    vec++;
    if (k !== 3 || ak !== 1 || er !== 0) begin
      errs++; $display("FAIL basic_write_ack: k=%0d ack=%b err=%b want k=3 ack=1 err=0", k, ak, er);
    end
    vec++;
    if (st !== 2) begin errs++; $display("FAIL basic_stall_cycles: got %0d want 2", st); end
    vec++;
    if (rd !== 32'hDEADBEEF || tl !== 0) begin
      errs++; $display("FAIL basic_write_data: got %h tail %b want deadbeef tail 0", rd, tl);
    end
    txn(0, 30'h10, 32'h0, 4'h0, k, ak, er, rd, st, tl);
    vec++;
    if (k !== 3 || ak !== 1 || rd !== 32'hDEADBEEF) begin
      errs++; $display("FAIL basic_read: k=%0d ack=%b data=%h want 3 1 deadbeef", k, ak, rd);
    end
    last_a = 32'hDEADBEEF;
  endtask
  task automatic test_byte_sel();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    txn(1, 30'h20, 32'h11223344, 4'hF, k, ak, er, rd, st, tl);
    txn(1, 30'h20, 32'hAABBCCDD, 4'b0101, k, ak, er, rd, st, tl);
    mdl[30'h20] = merge(32'h11223344, 32'hAABBCCDD, 4'b0101);
    vec++;
    if (ak !== 1 || rd !== 32'h11BB33DD) begin
      errs++; $display("FAIL bytesel_ack_data: ack=%b data=%h want 1 11bb33dd", ak, rd);
    end
    txn(0, 30'h20, 32'h0, 4'h0, k, ak, er, rd, st, tl);
    vec++;
    if (ak !== 1 || rd !== mdl[30'h20]) begin
      errs++; $display("FAIL bytesel_readback: ack=%b data=%h want 1 %h", ak, rd, mdl[30'h20]);
    end
    last_a = rd;
  endtask
  task automatic test_unmapped();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    logic [29:0] bad [2];
    bad[0] = 30'h0000_4000; bad[1] = 30'h0040_0100;
    foreach (bad[i]) begin
      txn(0, bad[i], 32'h0, 4'h0, k, ak, er, rd, st, tl);
      vec++;
      if (k !== 1 || ak !== 0 || er !== 1 || rd !== last_a || tl !== 0 || st !== 0) begin
        errs++;
        $display("FAIL unmapped_%h: k=%0d ack=%b err=%b data=%h tail=%b want k=1 ack=0 err=1 data=%h",
                 bad[i], k, ak, er, rd, tl, last_a);
      end
    end
    txn(1, 30'h0040_0005, 32'h5A5A0005, 4'hF, k, ak, er, rd, st, tl);
    txn(0, 30'h0040_0005, 32'h0, 4'h0, k, ak, er, rd, st, tl);
    mdl[30'h0040_0005] = 32'h5A5A0005;
    vec++;
    if (k !== 3 || ak !== 1 || er !== 0 || rd !== 32'h5A5A0005) begin
      errs++; $display("FAIL bump_read: k=%0d ack=%b err=%b data=%h want 3 1 0 5a5a0005", k, ak, er, rd);
    end
    last_a = 32'h5A5A0005;
  endtask
  task automatic test_back_to_back();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    int bad_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mdl[i] = $urandom;
      txn(1, 30'(i), mdl[i], 4'hF, k, ak, er, rd, st, tl);
    end
    @(negedge clk);
    cyc = 1; we = 0; sel = 4'h0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        vec++;
        if (ifb.stall !== 0 || ifb.ack !== 1 || ifb.rdata !== mdl[i-1]) begin
          errs++;
          $display("FAIL b2b_read%0d: stall=%b ack=%b data=%h want 0 1 %h", i - 1, ifb.stall, ifb.ack, ifb.rdata, mdl[i-1]);
        end
      end
      if (i < 4) begin stb = 1; addr = 30'(i); end else stb = 0;
      @(negedge clk);
    end
    vec++;
    if (ifb.ack !== 0 || ifb.stall !== 0) begin
      errs++; $display("FAIL b2b_end: ack=%b stall=%b want 0 0", ifb.ack, ifb.stall);
    end
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bad_cnt += int'(ifa.ack | ifa.err);
    end
    last_a = mdl[0];
    vec++;
    if (bad_cnt !== 0 || busy_a !== 0) begin
      errs++; $display("FAIL b2b_a_abort: stray=%0d busy=%b want 0 0", bad_cnt, busy_a);
    end
  endtask
  task automatic test_abort();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    int stray = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 30'h10;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (ifa.stall !== 1) begin errs++; $display("FAIL abort_busy: stall=%b want 1", ifa.stall); end
    cyc = 0; stb = 0;
    @(negedge clk);
    vec++;
    if (busy_a !== 0 || ifa.ack !== 0 || ifa.err !== 0) begin
      errs++; $display("FAIL abort_idle: busy=%b ack=%b err=%b want 0 0 0", busy_a, ifa.ack, ifa.err);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stray += int'(ifa.ack | ifa.err);
    end
    vec++;
    if (stray !== 0) begin errs++; $display("FAIL abort_stray: got %0d responses want 0", stray); end
    txn(0, 30'h10, 32'h0, 4'h0, k, ak, er, rd, st, tl);
    vec++;
    if (k !== 3 || ak !== 1 || rd !== mdl[30'h10]) begin
      errs++; $display("FAIL abort_next: k=%0d ack=%b data=%h want 3 1 %h", k, ak, rd, mdl[30'h10]);
    end
    last_a = rd;
  endtask
  task automatic test_async_reset();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    int stray = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = 30'h20;
    @(posedge clk);
    @(negedge clk);
    stb = 0;
    #2 rst_n = 0;
    #1;
    vec++;
    if ({ifa.ack, ifa.err, ifa.stall, busy_a, ifb.ack, busy_b} !== 6'b0 || ifa.rdata !== 32'd0) begin
      errs++;
      $display("FAIL async_reset: a ack%b err%b stall%b busy%b data %h b ack%b busy%b want all 0",
               ifa.ack, ifa.err, ifa.stall, busy_a, ifa.rdata, ifb.ack, busy_b);
    end
    cyc = 0;
    @(negedge clk);
    rst_n = 1;
    last_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stray += int'(ifa.ack | ifa.err | ifb.ack | ifb.err);
    end
    vec++;
    if (stray !== 0) begin errs++; $display("FAIL async_reset_stray: got %0d want 0", stray); end
    txn(0, 30'h20, 32'h0, 4'h0, k, ak, er, rd, st, tl);
    vec++;
    if (ak !== 1 || rd !== mdl[30'h20]) begin
      errs++; $display("FAIL async_reset_ram_kept: ack=%b data=%h want 1 %h", ak, rd, mdl[30'h20]);
    end
    last_a = rd;
  endtask
  task automatic test_random();
    int k, st; logic ak, er, tl; logic [31:0] rd;
    logic [29:0] pool [12];
    logic [29:0] ubase [4];
    logic [29:0] a; logic w; logic [31:0] d, exp_d; logic [3:0] s;
    bit m;
    ubase[0] = 30'h4000; ubase[1] = 30'h400100; ubase[2] = 30'h800000; ubase[3] = 30'h3FFFFF00;
    for (int i = 0; i < 8; i++) pool[i] = (i < 5) ? 30'(i + 8) : 30'h400000 + 30'(i);
    pool[8] = 30'd16383; pool[9] = 30'h4000FF; pool[10] = 30'h400000; pool[11] = 30'd1000;
    foreach (pool[i]) begin
      d = $urandom;
      txn(1, pool[i], d, 4'hF, k, ak, er, rd, st, tl);
      mdl[pool[i]] = d;
      last_a = d;
      vec++;
      if (ak !== 1 || rd !== d) begin
        errs++; $display("FAIL rand_preload_%h: ack=%b data=%h want 1 %h", pool[i], ak, rd, d);
      end
    end
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? ubase[$urandom_range(0, 3)] + 30'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      m = is_mapped(a);
      txn(w, a, d, s, k, ak, er, rd, st, tl);
      exp_d = !m ? last_a : w ? merge(mdl[a], d, s) : mdl[a];
      if (m) begin mdl[a] = exp_d; last_a = exp_d; end
      vec++;
      if (k !== (m ? 3 : 1) || ak !== m || er !== !m || rd !== exp_d || tl !== 0 || st !== (m ? 2 : 0)) begin
        errs++;
        $display("FAIL rand_%0d addr %h we %b sel %h: k=%0d ack=%b err=%b data=%h stall=%0d tail=%b want k=%0d ack=%b data=%h",
                 n, a, w, s, k, ak, er, rd, st, tl, m ? 3 : 1, m, exp_d);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_byte_sel();
    test_unmapped();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
